// File: rtl/spdif_channel_status_controller.sv
// S/PDIF consumer channel-status scheduler (clk128 domain).
// Follows the encoder's sub_frame_number, emits the channel-status (C) bit for
// each subframe, double-buffers configuration so it only changes on a block
// boundary, counts blocks and flags subframe sequence discontinuities.
//
// Configuration handshake: a transfer happens on any rising clk128 edge where
// cfg_valid && cfg_ready. The offered fields are then held in a pending buffer
// and cfg_ready stays low until that buffer is applied at the next block start.
// Offers made while cfg_ready is low are ignored. cfg_valid may drop at any time.
module spdif_channel_status_controller #(
  parameter bit         ENABLE_CH_NUM       = 1'b1,
  parameter logic [3:0] DEFAULT_SAMPLE_RATE = 4'b0000,
  parameter logic [3:0] DEFAULT_WORD_LENGTH = 4'b1011,
  parameter logic       DEFAULT_COPY_PERMIT = 1'b1
) (
  input  logic        clk128,
  input  logic        reset,
  input  logic [8:0]  sub_frame_number,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_copy_permit,
  input  logic        cfg_pre_emphasis,
  input  logic [7:0]  cfg_category,
  input  logic [3:0]  cfg_sample_rate,
  input  logic [3:0]  cfg_word_length,
  output logic        control_bit,
  output logic        block_start,
  output logic        cfg_applied,
  output logic [15:0] block_count,
  output logic        seq_error
);

  typedef struct packed {
    logic       copy_permit;
    logic       pre_emphasis;
    logic [7:0] category;
    logic [3:0] sample_rate;
    logic [3:0] word_length;
  } cs_cfg_t;

  localparam logic [8:0] LAST_SFN = 9'd383;

  localparam cs_cfg_t DEFAULT_CFG = '{
    copy_permit:  DEFAULT_COPY_PERMIT,
    pre_emphasis: 1'b0,
    category:     8'h00,
    sample_rate:  DEFAULT_SAMPLE_RATE,
    word_length:  DEFAULT_WORD_LENGTH
  };

  logic [8:0] prev_sfn;
  cs_cfg_t    active_cfg;
  cs_cfg_t    pending_cfg;
  logic       pending_valid;

  logic       new_sf;
  logic       sfn_in_range;
  logic [8:0] expected_sfn;
  logic       at_block_start;
  logic       do_apply;
  logic       cfg_take;
  cs_cfg_t    bit_cfg;
  cs_cfg_t    offered_cfg;
  logic [7:0] cs_index;
  logic [3:0] ch_num;
  logic       next_bit;

  // The pending buffer is the only thing holding the handshake closed.
  assign cfg_ready = ~pending_valid;
  assign cfg_take  = cfg_valid & cfg_ready;

  assign new_sf         = (prev_sfn != sub_frame_number);
  assign sfn_in_range   = (sub_frame_number <= LAST_SFN);
  assign expected_sfn   = (prev_sfn >= LAST_SFN) ? 9'd0 : prev_sfn + 9'd1;
  assign at_block_start = new_sf && (sub_frame_number == 9'd0);
  // A transfer in the same cycle as a block start only lands in pending,
  // because pending_valid is still low here.
  assign do_apply       = at_block_start && pending_valid;
  // Subframe 0 of a block that applies new config must already use it.
  assign bit_cfg        = do_apply ? pending_cfg : active_cfg;

  assign offered_cfg = '{
    copy_permit:  cfg_copy_permit,
    pre_emphasis: cfg_pre_emphasis,
    category:     cfg_category,
    sample_rate:  cfg_sample_rate,
    word_length:  cfg_word_length
  };

  // Channel-status bit lookup for the incoming subframe (LSB-first fields).
  always_comb begin
    next_bit = 1'b0;
    cs_index = sub_frame_number[8:1];
    ch_num   = sub_frame_number[0] ? 4'b0010 : 4'b0001;
    if (sfn_in_range) begin
      if (cs_index == 8'd2) begin
        next_bit = bit_cfg.copy_permit;
      end else if (cs_index == 8'd3) begin
        next_bit = bit_cfg.pre_emphasis;
      end else if (cs_index >= 8'd8 && cs_index <= 8'd15) begin
        next_bit = bit_cfg.category[cs_index[2:0]];
      end else if (cs_index >= 8'd20 && cs_index <= 8'd23) begin
        next_bit = ENABLE_CH_NUM ? ch_num[cs_index[1:0]] : 1'b0;
      end else if (cs_index >= 8'd24 && cs_index <= 8'd27) begin
        next_bit = bit_cfg.sample_rate[cs_index[1:0]];
      end else if (cs_index >= 8'd32 && cs_index <= 8'd35) begin
        next_bit = bit_cfg.word_length[cs_index[1:0]];
      end
    end
  end

  // Subframe tracking: change detection, block counting, sticky discontinuity flag.
  always_ff @(posedge clk128 or posedge reset) begin
    if (reset) begin
      prev_sfn    <= LAST_SFN;
      block_start <= 1'b0;
      block_count <= 16'd0;
      seq_error   <= 1'b0;
    end else begin
      block_start <= at_block_start;
      if (new_sf) begin
        prev_sfn <= sub_frame_number;
        if (!sfn_in_range || sub_frame_number != expected_sfn) begin
          seq_error <= 1'b1;
        end
      end
      if (at_block_start) begin
        block_count <= block_count + 16'd1;
      end
    end
  end

  // Configuration double buffer: capture on handshake, apply at block start.
  always_ff @(posedge clk128 or posedge reset) begin
    if (reset) begin
      active_cfg    <= DEFAULT_CFG;
      pending_cfg   <= DEFAULT_CFG;
      pending_valid <= 1'b0;
      cfg_applied   <= 1'b0;
    end else begin
      cfg_applied <= do_apply;
      if (do_apply) begin
        active_cfg    <= pending_cfg;
        pending_valid <= 1'b0;
      end else if (cfg_take) begin
        pending_cfg   <= offered_cfg;
        pending_valid <= 1'b1;
      end
    end
  end

  // C bit register: refreshed once per new subframe, held otherwise.
  always_ff @(posedge clk128 or posedge reset) begin
    if (reset) begin
      control_bit <= 1'b0;
    end else if (new_sf) begin
      control_bit <= next_bit;
    end
  end

endmodule

// File: doc/spdif_channel_status_controller.md
Name: spdif_channel_status_controller

Overview:
- Schedules the per-subframe channel-status (C) bit for the S/PDIF frame encoder, in the clk128 domain.
- Tracks the encoder's sub_frame_number and builds a 192-bit consumer channel-status block from a configuration word. Both the encoder and this block run on clk128.
- Accepts configuration through a valid/ready handshake and applies it only at a block boundary, so a block is never mixed.
- Flags discontinuities in the subframe sequence.

Parameters:
- ENABLE_CH_NUM, 1, 1: insert channel number in bits 20-23 (left=4'b0001, right=4'b0010). 0: bits 20-23 = 0.
- DEFAULT_SAMPLE_RATE, 4'b0000, reset value of the sample-frequency field (0000 = 44.1 kHz).
- DEFAULT_WORD_LENGTH, 4'b1011, reset value of the word-length field (24-bit).
- DEFAULT_COPY_PERMIT, 1'b1, reset value of bit 2.

Ports:
- clk128  input  1  master clock (x128 fs)
- reset  input  1  asynchronous, active-high reset
- sub_frame_number  input  9  current subframe index from the encoder, 0..383
- cfg_valid  input  1  configuration offer
- cfg_ready  output  1  configuration accepted when high with cfg_valid
- cfg_copy_permit  input  1  bit 2
- cfg_pre_emphasis  input  1  1: bits 3-5 = 3'b100 (LSB-first 50/15 us); 0: 3'b000
- cfg_category  input  8  bits 8-15
- cfg_sample_rate  input  4  bits 24-27
- cfg_word_length  input  4  bits 32-35
- control_bit  output  1  C bit for the current subframe, drives the encoder i_control
- block_start  output  1  one-cycle pulse when subframe 0 begins
- cfg_applied  output  1  one-cycle pulse when pending configuration becomes active
- block_count  output  16  blocks started since reset, wraps at 65535->0
- seq_error  output  1  sticky discontinuity flag, cleared only by reset

Behaviour:
- Reset values: control_bit=0, cfg_ready=1, block_start=0, cfg_applied=0, block_count=0, seq_error=0.
- Reset values of internal state:
  - Active config = parameter defaults, pre_emphasis=0, category=0.
  - No pending config.
  - prev_sfn = 9'd383.
- Change detection: a new subframe is declared in the cycle where the registered prev_sfn != sub_frame_number; prev_sfn then updates.
- Expected successor: prev_sfn+1, with 383->0 wrap.
- On a new subframe that is not the expected successor, or a sub_frame_number > 383: seq_error is set the next cycle.
  - The block still follows the new value; no resynchronisation stall.
- Channel-status bit index = sub_frame_number[8:1]. Channel = sub_frame_number[0] (0 = left).
- Block layout, with bit i sent in frame i:
  - bit0=0 (consumer), bit1=0 (audio), bit2=copy_permit, bits3-5=emphasis, bits6-7=0.
  - bits8-15=category (bit8 = category[0]), bits16-19=0, bits20-23=channel number per ENABLE_CH_NUM.
  - bits24-27=sample_rate (bit24 = LSB), bits28-29=0 (level II accuracy), bits30-31=0.
  - bits32-35=word_length, bits36-191=0.
- control_bit is registered and updated 1 clk128 after a new subframe is detected. It holds for the rest of the subframe.
- Out-of-range sub_frame_number (>383): control_bit=0.
- Configuration handshake:
  - Transfer when cfg_valid && cfg_ready. The inputs are captured into a pending register and cfg_ready drops the next cycle.
  - cfg_ready stays low until the pending config is applied.
  - Inputs are ignored while cfg_ready=0.
- Apply:
  - On a new subframe with sub_frame_number==0 and pending present: active <= pending, cfg_applied pulses, cfg_ready returns to 1 on the following cycle.
  - The bit for subframe 0 uses the newly applied config.
- Simultaneous transfer and block-start detection in the same cycle: the config is captured as pending only. It is applied at the next block start, never in the current one.
- block_start pulses and block_count increments on every new subframe equal to 0, including one reached by a discontinuity.
- Reset mid-block: everything returns to reset values immediately and any pending config is discarded.
- After reset with sub_frame_number==0: prev_sfn=383 makes 0 the expected successor, so the first block starts cleanly with no seq_error.

Test Plan:
- Defaults, sequential 0..383 with 64 clk per subframe:
  - C pattern: frame 2=1, frames 20 (left only) and 21 (right only)=1, frames 24-27=0, frames 32,33,35=1 (1011), all others=0.
  - block_start once per 384 subframes; seq_error=0.
- Config mid-block at subframe 100 (category=8'h01, sample_rate=4'b0010, pre_emphasis=1):
  - cfg_ready=0 until the next block; old pattern through subframe 383.
  - cfg_applied at subframe 0; new block shows frame 8=1, frame 25=1, frame 3=1.
- cfg_valid asserted in the exact cycle subframe 0 is detected:
  - Not applied in this block; applied at the following block start.
- Jump sub_frame_number from 57 to 200:
  - seq_error=1 one cycle later and stays set.
  - control_bit follows index 100.
- Force sub_frame_number=400: control_bit=0, seq_error=1.
- Reset at subframe 150 with a config pending:
  - All outputs return to reset values and cfg_ready=1.
  - The next block uses the defaults.
- Run 65537 blocks: block_count wraps to 1.
